// File: rtl/alu_mdu_pkg.sv
// Shared ALU/MDU definitions: opcode encodings, default width and FSM state type.
package alu_mdu_pkg;

    localparam int ALU_OP_WIDTH = 4;
    localparam int CPU_WIDTH    = 32;

    typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_AND  = 4'd2;
    localparam alu_op_t ALU_OR   = 4'd3;
    localparam alu_op_t ALU_XOR  = 4'd4;
    localparam alu_op_t ALU_SLL  = 4'd5;
    localparam alu_op_t ALU_SRL  = 4'd6;
    localparam alu_op_t ALU_SRA  = 4'd7;
    localparam alu_op_t ALU_SLT  = 4'd8;
    localparam alu_op_t ALU_SLTU = 4'd9;
    localparam alu_op_t ALU_MUL  = 4'd10;
    localparam alu_op_t ALU_DIV  = 4'd11;
    localparam alu_op_t ALU_DIVU = 4'd12;
    localparam alu_op_t ALU_REM  = 4'd13;
    localparam alu_op_t ALU_REMU = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_iter_op(input alu_op_t op);
        case (op)
            ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_div(input alu_op_t op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response handshake bundle between the EX stage and the ALU/MDU.
interface alu_mdu_if #(
    parameter int XLEN     = alu_mdu_pkg::CPU_WIDTH,
    parameter int OP_WIDTH = alu_mdu_pkg::ALU_OP_WIDTH
);
    logic                in_valid;
    logic                in_ready;
    logic [OP_WIDTH-1:0] alu_op;
    logic [XLEN-1:0]     alu_src1;
    logic [XLEN-1:0]     alu_src2;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     alu_res;
    logic                zero;
    logic                busy;

    modport master (
        output in_valid, alu_op, alu_src1, alu_src2, out_ready,
        input  in_ready, out_valid, alu_res, zero, busy
    );

    modport slave (
        input  in_valid, alu_op, alu_src1, alu_src2, out_ready,
        output in_ready, out_valid, alu_res, zero, busy
    );
endinterface

// File: rtl/alu_mdu_mdu_iter.sv
// Iterative multiply / restoring divide: XLEN steps after start, done on the last step.
module mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = CPU_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            start,
    input  alu_op_t         op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int            CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic            active_r;
    logic [CW-1:0]   count_r;
    alu_op_t         op_r;
    logic [XLEN-1:0] acc_r, a_r, b_r, src1_r;
    logic            neg_q_r, neg_r_r, dz_r;

    logic            sgn_s;
    logic [XLEN-1:0] mag1_s, mag2_s, acc_n_s, a_n_s, b_n_s, quo_s, rem_s;
    logic [XLEN:0]   shifted_s, diff_s;

    // MUL is never signed here, so the "magnitudes" are the raw operands for it
    assign sgn_s     = is_signed_div(op);
    assign mag1_s    = (sgn_s && src1[XLEN-1]) ? ({XLEN{1'b0}} - src1) : src1;
    assign mag2_s    = (sgn_s && src2[XLEN-1]) ? ({XLEN{1'b0}} - src2) : src2;
    assign shifted_s = {acc_r, a_r[XLEN-1]};
    assign diff_s    = shifted_s - {1'b0, b_r};
    assign done      = active_r && (count_r == CNT_ONE);

    // One shift-add or restoring-subtract step from the current partial state
    always_comb begin
        acc_n_s = acc_r;
        a_n_s   = a_r;
        b_n_s   = b_r;
        if (op_r == ALU_MUL) begin
            acc_n_s = b_r[0] ? (acc_r + a_r) : acc_r;
            a_n_s   = {a_r[XLEN-2:0], 1'b0};
            b_n_s   = {1'b0, b_r[XLEN-1:1]};
        end else if (!diff_s[XLEN]) begin
            acc_n_s = diff_s[XLEN-1:0];
            a_n_s   = {a_r[XLEN-2:0], 1'b1};
        end else begin
            acc_n_s = shifted_s[XLEN-1:0];
            a_n_s   = {a_r[XLEN-2:0], 1'b0};
        end
    end

    // Sign and divide-by-zero fix-up on the values produced by the final step
    always_comb begin
        quo_s  = neg_q_r ? ({XLEN{1'b0}} - a_n_s) : a_n_s;
        rem_s  = neg_r_r ? ({XLEN{1'b0}} - acc_n_s) : acc_n_s;
        result = acc_n_s;
        case (op_r)
            ALU_MUL:           result = acc_n_s;
            ALU_DIV, ALU_DIVU: result = dz_r ? {XLEN{1'b1}} : quo_s;
            ALU_REM, ALU_REMU: result = dz_r ? src1_r : rem_s;
            default:           result = acc_n_s;
        endcase
    end

    // Operand capture on start, then one step per cycle until the counter expires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= 1'b0;
            count_r  <= {CW{1'b0}};
            op_r     <= ALU_ADD;
            acc_r    <= {XLEN{1'b0}};
            a_r      <= {XLEN{1'b0}};
            b_r      <= {XLEN{1'b0}};
            src1_r   <= {XLEN{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dz_r     <= 1'b0;
        end else if (clear) begin
            active_r <= 1'b0;
            count_r  <= {CW{1'b0}};
        end else if (start) begin
            active_r <= 1'b1;
            count_r  <= CNT_LOAD;
            op_r     <= op;
            acc_r    <= {XLEN{1'b0}};
            a_r      <= mag1_s;
            b_r      <= mag2_s;
            src1_r   <= src1;
            neg_q_r  <= sgn_s && (src1[XLEN-1] ^ src2[XLEN-1]);
            neg_r_r  <= sgn_s && src1[XLEN-1];
            dz_r     <= (src2 == {XLEN{1'b0}});
        end else if (active_r) begin
            acc_r    <= acc_n_s;
            a_r      <= a_n_s;
            b_r      <= b_n_s;
            count_r  <= count_r - CNT_ONE;
            active_r <= (count_r != CNT_ONE);
        end else begin
            active_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked EX-stage ALU: single-cycle base ops plus iterative MUL/DIV/REM via mdu_iter.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN     = CPU_WIDTH,
    parameter int OP_WIDTH = ALU_OP_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    alu_mdu_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    state_t              state_r;
    logic [XLEN-1:0]     res_r;
    logic                zero_r, out_valid_r, busy_r;

    logic [OP_WIDTH-1:0] op_s;
    logic [XLEN-1:0]     src1_s, src2_s, base_res_s, mdu_res_s;
    logic [SHW-1:0]      shamt_s;
    logic                in_ready_s, accept_s, iter_s, mdu_start_s, mdu_done_s;

    assign op_s        = bus.alu_op;
    assign src1_s      = bus.alu_src1;
    assign src2_s      = bus.alu_src2;
    assign shamt_s     = src2_s[SHW-1:0];
    assign in_ready_s  = (state_r == S_IDLE) || ((state_r == S_DONE) && bus.out_ready);
    // A request coinciding with flush is dropped, never half-accepted
    assign accept_s    = bus.in_valid && in_ready_s && !flush;
    assign iter_s      = is_iter_op(op_s);
    assign mdu_start_s = accept_s && iter_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.alu_res   = res_r;
    assign bus.zero      = zero_r;
    assign bus.busy      = busy_r;

    // Combinational base ops; unknown opcodes fall back to SUB
    always_comb begin
        base_res_s = src1_s - src2_s;
        case (op_s)
            ALU_ADD:  base_res_s = src1_s + src2_s;
            ALU_SUB:  base_res_s = src1_s - src2_s;
            ALU_AND:  base_res_s = src1_s & src2_s;
            ALU_OR:   base_res_s = src1_s | src2_s;
            ALU_XOR:  base_res_s = src1_s ^ src2_s;
            ALU_SLL:  base_res_s = src1_s << shamt_s;
            ALU_SRL:  base_res_s = src1_s >> shamt_s;
            ALU_SRA:  base_res_s = $unsigned($signed(src1_s) >>> shamt_s);
            ALU_SLT:  base_res_s = {{(XLEN-1){1'b0}}, ($signed(src1_s) < $signed(src2_s))};
            ALU_SLTU: base_res_s = {{(XLEN-1){1'b0}}, (src1_s < src2_s)};
            default:  base_res_s = src1_s - src2_s;
        endcase
    end

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (flush),
        .start  (mdu_start_s),
        .op     (op_s),
        .src1   (src1_s),
        .src2   (src2_s),
        .done   (mdu_done_s),
        .result (mdu_res_s)
    );

    // Control FSM with registered result, zero, valid and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            res_r       <= {XLEN{1'b0}};
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (flush) begin
            state_r     <= S_IDLE;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (accept_s && iter_s) begin
                        state_r     <= S_BUSY;
                        busy_r      <= 1'b1;
                        out_valid_r <= 1'b0;
                        zero_r      <= 1'b0;
                    end else if (accept_s) begin
                        state_r     <= S_DONE;
                        res_r       <= base_res_s;
                        zero_r      <= (base_res_s == {XLEN{1'b0}});
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else if ((state_r == S_DONE) && bus.out_ready) begin
                        state_r     <= S_IDLE;
                        out_valid_r <= 1'b0;
                        zero_r      <= 1'b0;
                    end else begin
                        state_r     <= state_r;
                    end
                end
                S_BUSY: begin
                    if (mdu_done_s) begin
                        state_r     <= S_DONE;
                        res_r       <= mdu_res_s;
                        zero_r      <= (mdu_res_s == {XLEN{1'b0}});
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r     <= S_BUSY;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: base ops, MUL/DIV timing and boundaries, backpressure, flush, reset.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            zero;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    alu_mdu_if #(.XLEN(XLEN), .OP_WIDTH(ALU_OP_WIDTH)) bus();

    alu_mdu #(.XLEN(XLEN), .OP_WIDTH(ALU_OP_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_exp;

    // Every consumed result is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got res=%h zero=%b required no result", bus.alu_res, bus.zero);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.alu_res !== mon_exp.res || bus.zero !== mon_exp.zero) begin
                    errors++;
                    $display("FAIL sb_result got res=%h zero=%b required res=%h zero=%b",
                             bus.alu_res, bus.zero, mon_exp.res, mon_exp.zero);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input alu_op_t op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input bit track, input logic [XLEN-1:0] exp_res, output int waited);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.alu_src1 = a;
        bus.alu_src2 = b;
        if (track) sb.push_back({exp_res, (exp_res == {XLEN{1'b0}})});
        waited = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout op=%0d got in_ready=0 required 1 within 100 cycles", op);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 60);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.zero, bus.busy} !== 3'b000 || bus.alu_res !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got valid/zero/busy=%b res=%h required 000 res=0",
                     {bus.out_valid, bus.zero, bus.busy}, bus.alu_res);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_base();
        alu_op_t         ops[12] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
                                     ALU_SRL, ALU_SRA, ALU_SLTU, ALU_SLT, 4'hF, ALU_ADD};
        logic [XLEN-1:0] as[12]  = '{32'd5, 32'd9, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'd1,
                                     32'h80000000, 32'h80000000, 32'd1, 32'd5, 32'd10, 32'hFFFFFFFF};
        logic [XLEN-1:0] bs[12]  = '{32'd7, 32'd9, 32'h0FF0FF00, 32'h0FF0FF00, 32'h0FF0FF00, 32'h23,
                                     32'd4, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd3, 32'd1};
        logic [XLEN-1:0] es[12]  = '{32'd12, 32'd0, 32'h00F01200, 32'hFFF0FF34, 32'hFF00ED34, 32'd8,
                                     32'h08000000, 32'hF8000000, 32'd1, 32'd0, 32'd7, 32'd0};
        int w, lat;
        for (int i = 0; i < 12; i++) begin
            send(ops[i], as[i], bs[i], 1'b1, es[i], w);
            wait_out(lat);
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL base_latency idx=%0d got %0d required 1", i, lat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int w;
        send(ALU_ADD, 32'd100, 32'd1, 1'b1, 32'd101, w);
        for (int i = 0; i < 3; i++) begin
            send(ALU_XOR, 32'hA5A5A5A5, 32'(i), 1'b1, 32'hA5A5A5A5 ^ 32'(i), w);
            checks++;
            if (w !== 0) begin
                errors++;
                $display("FAIL b2b_bubble idx=%0d got wait=%0d required 0", i, w);
            end
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        int w, lat;
        send(ALU_MUL, 32'hFFFFFFFF, 32'd3, 1'b1, 32'hFFFFFFFD, w);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            checks++;
            if (k <= 32) begin
                if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b100) begin
                    errors++;
                    $display("FAIL mul_busy cycle=%0d got busy/in_ready/valid=%b required 100",
                             k, {bus.busy, bus.in_ready, bus.out_valid});
                end
            end else if ({bus.busy, bus.out_valid} !== 2'b01) begin
                errors++;
                $display("FAIL mul_done cycle=%0d got busy/valid=%b required 01", k, {bus.busy, bus.out_valid});
            end
        end
        @(posedge clk);
        #1;
        send(ALU_MUL, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFF1, w);
        wait_out(lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL mul_latency got %0d required 33", lat);
        end
        @(posedge clk);
        #1;
        send(ALU_MUL, 32'h00010000, 32'h00010000, 1'b1, 32'd0, w);
        wait_out(lat);
        @(posedge clk);
        #1;
    endtask

    task automatic test_div();
        alu_op_t         ops[10] = '{ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU, ALU_DIV,
                                     ALU_REM, ALU_DIV, ALU_REM, ALU_DIVU, ALU_REM};
        logic [XLEN-1:0] as[10]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000,
                                     32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd100, 32'd7};
        logic [XLEN-1:0] bs[10]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF,
                                     32'hFFFFFFFF, 32'd0, 32'd0, 32'd7, 32'hFFFFFFFE};
        logic [XLEN-1:0] es[10]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000,
                                     32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'd14, 32'd1};
        int w, lat;
        for (int i = 0; i < 10; i++) begin
            send(ops[i], as[i], bs[i], 1'b1, es[i], w);
            wait_out(lat);
            checks++;
            if (lat !== 33) begin
                errors++;
                $display("FAIL div_latency idx=%0d got %0d required 33", i, lat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int w, lat;
        bus.out_ready = 1'b0;
        send(ALU_ADD, 32'd10, 32'd20, 1'b1, 32'd30, w);
        wait_out(lat);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.zero, bus.in_ready} !== 3'b100 || bus.alu_res !== 32'd30) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got valid/zero/in_ready=%b res=%h required 100 res=0000001e",
                         k, {bus.out_valid, bus.zero, bus.in_ready}, bus.alu_res);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(ALU_ADD, 32'd2, 32'd3, 1'b1, 32'd5, w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL bp_accept got wait=%0d required 0", w);
        end
        wait_out(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL bp_latency got %0d required 1", lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        int  w, lat;
        bit  seen;
        send(ALU_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0, w);
        repeat (10) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_busy got %b required 1", bus.busy);
        end
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.alu_op    = ALU_ADD;
        bus.alu_src1  = 32'd3;
        bus.alu_src2  = 32'd4;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL flush_state got valid/busy/in_ready=%b required 001",
                     {bus.out_valid, bus.busy, bus.in_ready});
        end
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_no_result got out_valid=1 required 0");
        end
        // A request presented while flush is high in IDLE must be dropped
        @(posedge clk);
        #1;
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop got out_valid=%b required 0", bus.out_valid);
        end
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        send(ALU_ADD, 32'd1, 32'd1, 1'b1, 32'd2, w);
        wait_out(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL flush_next_latency got %0d required 1", lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        int w, lat;
        send(ALU_MUL, 32'd123, 32'd456, 1'b0, 32'd0, w);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.zero} !== 3'b000 || bus.alu_res !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_clear got valid/busy/zero=%b res=%h required 000 res=0",
                     {bus.out_valid, bus.busy, bus.zero}, bus.alu_res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_release got in_ready/busy/valid=%b required 100",
                     {bus.in_ready, bus.busy, bus.out_valid});
        end
        @(posedge clk);
        #1;
        send(ALU_SLT, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd1, w);
        wait_out(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL rst_mid_slt_latency got %0d required 1", lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.alu_op    = ALU_ADD;
        bus.alu_src1  = 32'h0;
        bus.alu_src2  = 32'h0;
        bus.out_ready = 1'b1;
        test_reset();
        test_base();
        test_back_to_back();
        test_mul();
        test_div();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending results required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, handshaked successor to the single-cycle ALU.
- Executes the base integer ops in one registered cycle.
- Executes MUL/DIV/REM class ops iteratively over XLEN cycles.
- Sits in EX. The pipeline stalls on in_ready/out_valid instead of assuming a fixed one-cycle result.

Parameters:
- XLEN, 32, operand/result width (any value >= 8).
- OP_WIDTH, 4, alu_op width; encodings come from the shared defines.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of any op in flight.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  unit accepts a new op this cycle.
- alu_op  in  OP_WIDTH  opcode.
- alu_src1  in  XLEN  source 1.
- alu_src2  in  XLEN  source 2.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- alu_res  out  XLEN  result.
- zero  out  1  alu_res == 0, qualified by out_valid.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - out_valid=0, alu_res=0, zero=0, busy=0, in_ready=1 after release.
- Ops:
  - ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU: single-cycle class.
  - MUL (low XLEN bits), DIV, DIVU, REM, REMU: iterative class.
  - Shift amount = src2[$clog2(XLEN)-1:0].
  - Undefined opcode behaves as SUB, keeping the legacy default.
- Handshake:
  - Accept when in_valid & in_ready.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Result holds stable while out_valid & !out_ready.
- FSM states IDLE, BUSY, DONE:
  - IDLE, accept single-cycle op -> DONE. Result is registered; out_valid=1 next cycle (latency 1).
  - IDLE, accept iterative op -> BUSY. Load counter = XLEN and busy=1.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV*) step per cycle. Counter decrements; at 0 -> DONE.
  - Iterative latency: out_valid rises exactly XLEN+1 cycles after the accept edge.
  - DONE & out_ready & !in_valid -> IDLE.
  - DONE & out_ready & in_valid -> accept the next op directly (back-to-back, no bubble for single-cycle ops).
- Signed divide:
  - Operate on magnitudes.
  - Quotient is negated if signs differ; remainder takes dividend sign.
- Division boundaries are RISC-V defined and still take the full XLEN+1 cycles:
  - Divisor 0: quotient all-ones, remainder = src1.
  - Signed overflow (src1 = -2^(XLEN-1), src2 = -1): quotient = src1, remainder = 0.
- zero is computed from the final alu_res for every op, not only SUB.
- flush:
  - Any state -> IDLE next cycle; out_valid=0, busy=0.
  - An in_valid in the same cycle as flush is not accepted.
  - Flush has priority over completion.
- Reset mid-op: immediate abandon, outputs to reset values; no partial result is ever presented.
- Operands are captured at accept; src changes during BUSY are ignored.

Decomposition:
- Shared defines file holds:
  - ALU_OP_WIDTH.
  - All ALU_* encodings, including new ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
  - CPU_WIDTH as the default XLEN.
- One sub-module, mdu_iter:
  - Owns the counter, the partial product/remainder registers and sign fix-up.
  - Interface is start/done.
- alu_mdu keeps the FSM, handshake and combinational base ops.

Test Plan:
1. ADD: 5 + 7 with out_ready=1 -> out_valid 1 cycle after accept, alu_res=12, zero=0. SUB 9-9 -> alu_res=0, zero=1.
2. MUL 0xFFFFFFFF * 3 (XLEN=32) -> alu_res=0xFFFFFFFD, out_valid exactly 33 cycles after accept, busy high for the 32 iterative cycles, in_ready=0 meanwhile.
3. Division boundaries:
   - DIV -7/2 -> -3; REM -7/2 -> -1.
   - DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
   - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
4. Backpressure: out_ready=0 for 5 cycles after a result -> alu_res/zero stable, in_ready=0. Then out_ready=1 with a queued ADD -> it is accepted that cycle and its result is valid next cycle.
5. flush on cycle 10 of a DIVU -> out_valid never asserts for it, state IDLE, in_ready=1 next cycle. A following ADD 1+1 returns 2.
6. rst_n pulsed low mid-MUL (asynchronously, between edges) -> out_valid, busy, alu_res clear immediately. After release, in_ready=1 and a fresh SLT -1 < 1 returns 1.
